// File: rtl/proc_mem_arbiter.sv
// Merges the TinyRV1 fetch and data val/wait ports onto one memory port.
// Same-cycle conflicts serialize fetch-then-data; both ports finish together.
module proc_mem_arbiter #(
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   imem_val,
  output logic                   imem_wait,
  input  logic [31:0]            imem_addr,
  output logic [31:0]            imem_rdata,
  input  logic                   dmem_val,
  output logic                   dmem_wait,
  input  logic                   dmem_type,
  input  logic [31:0]            dmem_addr,
  input  logic [31:0]            dmem_wdata,
  output logic [31:0]            dmem_rdata,
  output logic                   mem_val,
  input  logic                   mem_wait,
  output logic                   mem_type,
  output logic [31:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic [p_cnt_nbits-1:0] conflicts
);

  typedef enum logic {
    S_IMEM,
    S_DMEM
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            ibuf_q, ibuf_d;
  logic [p_cnt_nbits-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IMEM;
      ibuf_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ibuf_q  <= ibuf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ibuf_d     = ibuf_q;
    cnt_d      = cnt_q;
    mem_val    = 1'b0;
    mem_type   = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    imem_wait  = 1'b0;
    dmem_wait  = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    if (rst) begin
      imem_wait = 1'b1;
      dmem_wait = 1'b1;
    end else begin
      unique case (state_q)
        S_IMEM: begin
          if (imem_val) begin
            mem_val  = 1'b1;
            mem_addr = imem_addr;
            if (dmem_val) begin
              // fetch leg of a conflict: park the fetch data
              imem_wait = 1'b1;
              dmem_wait = 1'b1;
              if (!mem_wait) begin
                ibuf_d  = mem_rdata;
                state_d = S_DMEM;
              end
            end else begin
              imem_wait  = mem_wait;
              imem_rdata = mem_rdata;
            end
          end else if (dmem_val) begin
            mem_val    = 1'b1;
            mem_type   = dmem_type;
            mem_addr   = dmem_addr;
            mem_wdata  = dmem_wdata;
            dmem_wait  = mem_wait;
            dmem_rdata = mem_rdata;
          end
        end
        S_DMEM: begin
          imem_wait = 1'b1;
          dmem_wait = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (dmem_val) begin
            mem_val   = 1'b1;
            mem_type  = dmem_type;
            mem_addr  = dmem_addr;
            mem_wdata = dmem_wdata;
            if (!mem_wait) begin
              imem_wait  = 1'b0;
              dmem_wait  = 1'b0;
              imem_rdata = ibuf_q;
              dmem_rdata = dmem_type ? 32'h0 : mem_rdata;
              state_d    = S_IMEM;
            end
          end else begin
            // requester dropped the data access; discard the fetch too
            ibuf_d  = '0;
            state_d = S_IMEM;
          end
        end
        default: state_d = S_IMEM;
      endcase
    end
  end

  assign conflicts = cnt_q;

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Bench for proc_mem_arbiter: behavioural memory with programmable stalls,
// queue scoreboard of expected fetch/load data.
module tb_proc_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_val, imem_wait;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_val, dmem_wait, dmem_type;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_val, mem_wait, mem_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] conflicts;

  logic        s_imem_wait, s_dmem_wait;
  logic [31:0] s_imem_rdata, s_dmem_rdata;
  logic        s_mem_val, s_mem_type;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [1:0]  s_conflicts;

  always #5 clk = ~clk;

  proc_mem_arbiter #(.p_cnt_nbits(16)) dut (
    .clk(clk), .rst(rst),
    .imem_val(imem_val), .imem_wait(imem_wait),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_val(dmem_val), .dmem_wait(dmem_wait),
    .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .mem_val(mem_val), .mem_wait(mem_wait),
    .mem_type(mem_type), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflicts(conflicts)
  );

  proc_mem_arbiter #(.p_cnt_nbits(2)) dut_sat (
    .clk(clk), .rst(rst),
    .imem_val(imem_val), .imem_wait(s_imem_wait),
    .imem_addr(imem_addr), .imem_rdata(s_imem_rdata),
    .dmem_val(dmem_val), .dmem_wait(s_dmem_wait),
    .dmem_type(dmem_type), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(s_dmem_rdata),
    .mem_val(s_mem_val), .mem_wait(mem_wait),
    .mem_type(s_mem_type), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .conflicts(s_conflicts)
  );

  function automatic logic [31:0] pat(input logic [11:0] i);
    if (i == 12'h800) return 32'hcafe0001;
    return {20'ha5c3e, i} ^ 32'h13570000;
  endfunction

  logic [31:0] mem [0:4095];
  logic [31:0] refm [0:4095];
  bit          loaded = 1'b0;
  int          wait_cfg = 0;
  int          wait_next = 0;
  int          stall_left = 0;
  int          write_cnt = 0;

  assign mem_wait  = mem_val && (stall_left != 0);
  assign mem_rdata = (mem_val && !mem_type) ?
                     mem[mem_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(12'(i));
      loaded <= 1'b1;
    end
    if (rst || !mem_val) stall_left <= wait_cfg;
    else if (stall_left != 0) stall_left <= stall_left - 1;
    else begin
      if (mem_type) begin
        mem[mem_addr[13:2]] <= mem_wdata;
        write_cnt <= write_cnt + 1;
      end
      stall_left <= wait_next;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] iq [$];
  logic [31:0] dq [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic txn(input string tag, input bit iv,
                     input logic [31:0] ia, input bit dv, input bit dt,
                     input logic [31:0] da, input logic [31:0] dw,
                     input int exp_cyc);
    int          cyc = 0;
    int          ic = 0;
    int          dc = 0;
    bit          idone = !iv;
    bit          ddone = !dv;
    bit          pstall = 1'b0;
    logic [31:0] paddr = '0;
    if (iv) iq.push_back(refm[ia[13:2]]);
    if (dv) begin
      dq.push_back(dt ? 32'h0 : refm[da[13:2]]);
      if (dt) refm[da[13:2]] = dw;
    end
    imem_val   = iv;
    imem_addr  = ia;
    dmem_val   = dv;
    dmem_type  = dt;
    dmem_addr  = da;
    dmem_wdata = dw;
    while (!(idone && ddone) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pstall) check({tag, ".addr"}, mem_addr, paddr);
      pstall = mem_val && mem_wait;
      paddr  = mem_addr;
      if (!idone && !imem_wait) begin
        idone = 1'b1;
        ic    = cyc;
        check({tag, ".irdata"}, imem_rdata, iq.pop_front());
      end
      if (!ddone && !dmem_wait) begin
        ddone = 1'b1;
        dc    = cyc;
        check({tag, ".drdata"}, dmem_rdata, dq.pop_front());
      end
    end
    check({tag, ".done"}, 32'({idone, ddone}), 32'd3);
    if (iv && dv) check({tag, ".same"}, ic, dc);
    check({tag, ".cycles"}, cyc, exp_cyc);
    iq.delete();
    dq.delete();
    @(posedge clk);
    #1;
    imem_val = 1'b0;
    dmem_val = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w0;
    int c0;
    for (int i = 0; i < 4096; i++) refm[i] = pat(12'(i));
    rst        = 1'b1;
    imem_val   = 1'b1;
    dmem_val   = 1'b1;
    imem_addr  = 32'h200;
    dmem_addr  = 32'h2000;
    dmem_type  = 1'b1;
    dmem_wdata = 32'h5555aaaa;
    #12;
    check("rst.mem_val", 32'(mem_val), 32'd0);
    check("rst.iwait", 32'(imem_wait), 32'd1);
    check("rst.dwait", 32'(dmem_wait), 32'd1);
    check("rst.irdata", imem_rdata, 32'h0);
    check("rst.drdata", dmem_rdata, 32'h0);
    imem_val  = 1'b0;
    dmem_val  = 1'b0;
    dmem_type = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle.iwait", 32'(imem_wait), 32'd0);
    check("idle.dwait", 32'(dmem_wait), 32'd0);
    check("idle.mem_val", 32'(mem_val), 32'd0);
    check("idle.mem_addr", mem_addr, 32'h0);
    check("idle.cnt", 32'(conflicts), 32'd0);
    @(posedge clk);
    #1;

    txn("t1", 1, 32'h200, 0, 0, 0, 0, 1);
    check("t1.cnt", 32'(conflicts), 32'd0);

    txn("t2", 1, 32'h204, 1, 0, 32'h2000, 0, 2);
    check("t2.cnt", 32'(conflicts), 32'd1);

    w0 = write_cnt;
    txn("t3", 1, 32'h208, 1, 1, 32'h2004, 32'h12345678, 2);
    check("t3.writes", write_cnt - w0, 32'd1);
    txn("t3r", 0, 0, 1, 0, 32'h2004, 0, 1);
    check("t3r.writes", write_cnt - w0, 32'd1);
    check("t3.cnt", 32'(conflicts), 32'd2);

    wait_cfg  = 3;
    wait_next = 3;
    @(posedge clk);
    #1;
    c0 = 32'(conflicts);
    txn("t4", 1, 32'h20c, 1, 0, 32'h2010, 0, 8);
    check("t4.cnt", 32'(conflicts) - c0, 32'd4);
    txn("t4f", 1, 32'h210, 0, 0, 0, 0, 4);

    wait_cfg  = 0;
    wait_next = 5;
    @(posedge clk);
    #1;
    imem_val   = 1'b1;
    imem_addr  = 32'h208;
    dmem_val   = 1'b1;
    dmem_type  = 1'b1;
    dmem_addr  = 32'h2008;
    dmem_wdata = 32'hdeadbeef;
    @(negedge clk);
    check("t5.iwait0", 32'(imem_wait), 32'd1);
    check("t5.dwait0", 32'(dmem_wait), 32'd1);
    @(negedge clk);
    check("t5.dleg_val", 32'(mem_val), 32'd1);
    check("t5.dleg_type", 32'(mem_type), 32'd1);
    check("t5.dleg_addr", mem_addr, 32'h2008);
    w0 = write_cnt;
    rst = 1'b1;
    #1;
    check("t5.mem_val", 32'(mem_val), 32'd0);
    check("t5.iwait", 32'(imem_wait), 32'd1);
    check("t5.dwait", 32'(dmem_wait), 32'd1);
    check("t5.cnt_rst", 32'(conflicts), 32'd0);
    imem_val  = 1'b0;
    dmem_val  = 1'b0;
    wait_cfg  = 0;
    wait_next = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5.cnt", 32'(conflicts), 32'd0);
    @(posedge clk);
    #1;
    txn("t5f", 1, 32'h208, 0, 0, 0, 0, 1);
    txn("t5d", 0, 0, 1, 0, 32'h2008, 0, 1);
    check("t5.writes", write_cnt - w0, 32'd0);

    for (int i = 0; i < 5; i++) begin
      txn($sformatf("t6.%0d", i), 1, 32'h300 + 32'(4 * i),
          1, 0, 32'h2100 + 32'(4 * i), 0, 2);
      if (i == 1) check("t6.sat2", 32'(s_conflicts), 32'd2);
    end
    check("t6.cnt", 32'(conflicts), 32'd5);
    check("t6.sat", 32'(s_conflicts), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
